// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle ALU.
// Opcodes are held at 5 bits so the 4-bit legacy set and the mul/div set share one enum.
package alu_pkg;

  localparam int OPCODE_DECODE_W = 5;

  typedef enum logic [OPCODE_DECODE_W-1:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_SLT    = 5'b00011,
    OP_XOR    = 5'b00101,
    OP_SUB    = 5'b00110,
    OP_EQ     = 5'b01000,
    OP_SLTU   = 5'b01001,
    OP_SLL    = 5'b01010,
    OP_SRL    = 5'b01011,
    OP_ADD_L  = 5'b01100,
    OP_SRA    = 5'b01101,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only 10xxx codes run through the iterative datapath; 11xxx are undefined.
  function automatic logic is_muldiv(input logic [OPCODE_DECODE_W-1:0] code);
    return code[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply (shift-add) and divide (restoring) engine, one step per clock.
// Works on operand magnitudes; sign correction is folded into the final-step outputs.
module alu_muldiv_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mul_mode,
  input  logic                  a_signed,
  input  logic                  b_signed,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic          mul_q, mul_d;
  logic          neg_lo_q, neg_lo_d;
  logic          neg_hi_q, neg_hi_d;

  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    sum, shifted, diff;
  logic [W-1:0]  step_hi, step_lo;
  logic [2*W-1:0] prod_raw, prod_fix;

  // For mul: hi:lo is accumulator:multiplier. For div: hi:lo is remainder:quotient.
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, opnd_q};
    shifted = {hi_q, lo_q[W-1]};
    diff    = shifted - {1'b0, opnd_q};
    step_hi = hi_q;
    step_lo = lo_q;
    if (mul_q) begin
      if (lo_q[0]) begin
        step_hi = sum[W:1];
        step_lo = {sum[0], lo_q[W-1:1]};
      end else begin
        step_hi = {1'b0, hi_q[W-1:1]};
        step_lo = {hi_q[0], lo_q[W-1:1]};
      end
    end else if (!diff[W]) begin
      step_hi = diff[W-1:0];
      step_lo = {lo_q[W-2:0], 1'b1};
    end else begin
      step_hi = shifted[W-1:0];
      step_lo = {lo_q[W-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_raw = {step_hi, step_lo};
    prod_fix = neg_lo_q ? -prod_raw : prod_raw;
    if (mul_q) begin
      hi = prod_fix[2*W-1:W];
      lo = prod_fix[W-1:0];
    end else begin
      hi = neg_hi_q ? -step_hi : step_hi;
      lo = neg_lo_q ? -step_lo : step_lo;
    end
    done = busy_q && (cnt_q == LAST) && !abort;
  end

  always_comb begin
    a_neg    = a_signed && a[W-1];
    b_neg    = b_signed && b[W-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    mul_d    = mul_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      hi_d     = '0;
      lo_d     = a_mag;
      opnd_d   = b_mag;
      mul_d    = mul_mode;
      neg_lo_d = a_neg ^ b_neg;
      // Remainder takes the dividend's sign; a product has one sign for both halves.
      neg_hi_d = mul_mode ? (a_neg ^ b_neg) : a_neg;
    end else if (busy_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      mul_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      mul_q    <= mul_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// ALU with single-cycle logic/arith/shift ops and iterative mul/div behind a valid/ready FSM.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds data until then.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero,
  output logic [1:0]               dbg_state
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    sel_lo_q, sel_lo_d;

  logic [OPCODE_LENGTH+4:0] op_ext;
  logic [4:0]              code;
  logic                    code_in_range;
  logic [SHW-1:0]          shamt;
  logic                    b_zero, div_ovf;
  logic [DATA_WIDTH-1:0]   sc_result;
  logic                    go_iter, iter_mul, iter_a_signed, iter_b_signed, iter_sel_lo;
  logic                    accept, iter_start, iter_done;
  logic [DATA_WIDTH-1:0]   iter_hi, iter_lo;

  assign in_ready  = rst_n && (state_q == ST_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign ALUResult = result_q;
  assign Zero      = out_valid && (result_q == '0);
  assign dbg_state = state_q;

  // Wider opcodes only decode when their extra high bits are zero; a 4-bit opcode never reaches 1xxxx.
  always_comb begin
    op_ext        = {5'b00000, Operation};
    code          = op_ext[4:0];
    code_in_range = (op_ext[OPCODE_LENGTH+4:5] == '0);
    shamt         = SrcB[SHW-1:0];
    b_zero        = (SrcB == '0);
    div_ovf       = (SrcA == MIN_NEG) && (SrcB == '1);
    sc_result     = '0;
    go_iter       = 1'b0;
    iter_mul      = !code[2];
    iter_a_signed = 1'b0;
    iter_b_signed = 1'b0;
    iter_sel_lo   = 1'b0;
    if (code_in_range) begin
      case (code)
        OP_AND:          sc_result = SrcA & SrcB;
        OP_OR:           sc_result = SrcA | SrcB;
        OP_ADD, OP_ADD_L: sc_result = SrcA + SrcB;
        OP_SUB:          sc_result = SrcA - SrcB;
        OP_XOR:          sc_result = SrcA ^ SrcB;
        OP_SLT:          sc_result = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
        OP_SLTU:         sc_result = {{(DATA_WIDTH-1){1'b0}}, SrcA < SrcB};
        OP_EQ:           sc_result = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
        OP_SLL:          sc_result = SrcA << shamt;
        OP_SRL:          sc_result = SrcA >> shamt;
        OP_SRA:          sc_result = $unsigned($signed(SrcA) >>> shamt);
        OP_MUL:          begin go_iter = 1'b1; iter_sel_lo = 1'b1; end
        OP_MULH:         begin go_iter = 1'b1; iter_a_signed = 1'b1; iter_b_signed = 1'b1; end
        OP_MULHSU:       begin go_iter = 1'b1; iter_a_signed = 1'b1; end
        OP_MULHU:        go_iter = 1'b1;
        OP_DIV: begin
          iter_a_signed = 1'b1;
          iter_b_signed = 1'b1;
          iter_sel_lo   = 1'b1;
          if (b_zero)       sc_result = '1;
          else if (div_ovf) sc_result = SrcA;
          else              go_iter = 1'b1;
        end
        OP_DIVU: begin
          iter_sel_lo = 1'b1;
          if (b_zero) sc_result = '1;
          else        go_iter = 1'b1;
        end
        OP_REM: begin
          iter_a_signed = 1'b1;
          iter_b_signed = 1'b1;
          if (b_zero)       sc_result = SrcA;
          else if (div_ovf) sc_result = '0;
          else              go_iter = 1'b1;
        end
        OP_REMU: begin
          if (b_zero) sc_result = SrcA;
          else        go_iter = 1'b1;
        end
        default:         sc_result = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    sel_lo_d   = sel_lo_q;
    iter_start = 1'b0;
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (go_iter) begin
              state_d    = ST_BUSY;
              sel_lo_d   = iter_sel_lo;
              iter_start = 1'b1;
            end else begin
              state_d  = ST_DONE;
              result_d = sc_result;
            end
          end
        end
        ST_BUSY: begin
          if (iter_done) begin
            state_d  = ST_DONE;
            result_d = sel_lo_q ? iter_lo : iter_hi;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      sel_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      sel_lo_q <= sel_lo_d;
    end
  end

  alu_muldiv_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (iter_start),
    .abort    (flush),
    .mul_mode (iter_mul),
    .a_signed (iter_a_signed),
    .b_signed (iter_b_signed),
    .a        (SrcA),
    .b        (SrcB),
    .done     (iter_done),
    .hi       (iter_hi),
    .lo       (iter_lo)
  );

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at DATA_WIDTH=32, OPCODE_LENGTH=5.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  Operation;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  alu_multicycle #(
    .DATA_WIDTH   (32),
    .OPCODE_LENGTH(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Operation(Operation),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .Zero     (Zero),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1);
  end

  // Driver: present one op, wait for out_valid (bounded), return result and edges after accept.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    SrcA      = $urandom;
    SrcB      = $urandom;
    Operation = 5'($urandom_range(0, 31));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = ALUResult;
    z   = Zero;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    SrcA = '0; SrcB = '0; Operation = '0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0 || in_ready !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: ov=%b res=%h z=%b ir=%b st=%0d required ov=0 res=0 z=0 ir=0 st=0",
               out_valid, ALUResult, Zero, in_ready, dbg_state);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready: actual=%b required=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_cycle();
    vec_t v[$];
    logic [31:0] res;
    logic z;
    int lat;
    v.push_back('{OP_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        0});
    v.push_back('{OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h1,        0});
    v.push_back('{OP_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        0});
    v.push_back('{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0});
    v.push_back('{OP_OR,    32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 0});
    v.push_back('{OP_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0});
    v.push_back('{OP_SUB,   32'h3,        32'h5,        32'hFFFFFFFE, 0});
    v.push_back('{OP_EQ,    32'h1234,     32'h1234,     32'h1,        0});
    v.push_back('{OP_EQ,    32'h1234,     32'h1235,     32'h0,        0});
    v.push_back('{OP_ADD_L, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0});
    v.push_back('{OP_SLL,   32'h1,        32'd33,       32'h2,        0});
    v.push_back('{OP_SRL,   32'h80000000, 32'h4,        32'h08000000, 0});
    v.push_back('{OP_SRA,   32'h80000000, 32'h24,       32'hF8000000, 0});
    v.push_back('{5'b00100, 32'h5,        32'h6,        32'h0,        0});
    v.push_back('{5'b01110, 32'h5,        32'h6,        32'h0,        0});
    v.push_back('{5'b11000, 32'h5,        32'h6,        32'h0,        0});
    v.push_back('{5'b11111, 32'h5,        32'h6,        32'h0,        0});
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, res, z, lat);
      checks++;
      if (res !== v[i].exp || lat !== v[i].lat || z !== (v[i].exp == 32'h0)) begin
        failures++;
        $display("FAIL single op=%b a=%h b=%h: res=%h lat=%0d z=%b required res=%h lat=%0d z=%b",
                 v[i].op, v[i].a, v[i].b, res, lat, z, v[i].exp, v[i].lat, v[i].exp == 32'h0);
      end
    end
  endtask

  task automatic test_muldiv();
    vec_t v[$];
    logic [31:0] res;
    logic z;
    int lat;
    v.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 32});
    v.push_back('{OP_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 32});
    v.push_back('{OP_MUL,    32'd12345,    32'd1000,     32'h00BC5EA8, 32});
    v.push_back('{OP_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32});
    v.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32});
    v.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32});
    v.push_back('{OP_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32});
    v.push_back('{OP_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32});
    v.push_back('{OP_DIV,    32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32});
    v.push_back('{OP_REM,    32'h7,        32'hFFFFFFFE, 32'h1,        32});
    v.push_back('{OP_DIVU,   32'd100,      32'd7,        32'd14,       32});
    v.push_back('{OP_REMU,   32'd100,      32'd7,        32'd2,        32});
    v.push_back('{OP_DIVU,   32'd7,        32'd0,        32'hFFFFFFFF, 0});
    v.push_back('{OP_REMU,   32'd7,        32'd0,        32'd7,        0});
    v.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 0});
    v.push_back('{OP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0});
    v.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
    v.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        0});
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, res, z, lat);
      checks++;
      if (res !== v[i].exp || lat !== v[i].lat || z !== (v[i].exp == 32'h0)) begin
        failures++;
        $display("FAIL muldiv op=%b a=%h b=%h: res=%h lat=%0d z=%b required res=%h lat=%0d z=%b",
                 v[i].op, v[i].a, v[i].b, res, lat, z, v[i].exp, v[i].lat, v[i].exp == 32'h0);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; Operation = OP_ADD; SrcA = 32'd2; SrcB = 32'd3;
    @(posedge clk); #1;
    Operation = OP_SUB; SrcA = 32'd9; SrcB = 32'd1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || ALUResult !== 32'd5 || in_ready !== 1'b0 || Zero !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold cycle=%0d: ov=%b res=%h ir=%b z=%b required ov=1 res=5 ir=0 z=0",
                 c, out_valid, ALUResult, in_ready, Zero);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL backpressure_release: ov=%b st=%0d required ov=0 st=0", out_valid, dbg_state);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_ignored_input: ov=%b required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic z;
    int lat;
    logic seen;
    in_valid = 1'b1; Operation = OP_DIVU; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL flush_enter_busy: st=%0d required 1", dbg_state);
    end
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; Operation = OP_ADD; SrcA = 32'd1; SrcB = 32'd1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_ready: actual=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (dbg_state !== 2'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy_to_idle: st=%0d ov=%b required st=0 ov=0", dbg_state, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_result: out_valid seen=%b required 0", seen);
    end
    do_op(OP_ADD, 32'd2, 32'd3, res, z, lat);
    checks++;
    if (res !== 32'd5 || lat !== 0) begin
      failures++;
      $display("FAIL flush_next_add: res=%h lat=%0d required res=5 lat=0", res, lat);
    end
    // Flush while holding a completed result.
    out_ready = 1'b0;
    in_valid = 1'b1; Operation = OP_ADD; SrcA = 32'd4; SrcB = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0 || Zero !== 1'b0) begin
      failures++;
      $display("FAIL flush_done: ov=%b st=%0d z=%b required ov=0 st=0 z=0", out_valid, dbg_state, Zero);
    end
    // Flush beats a simultaneous accept in IDLE.
    flush = 1'b1; in_valid = 1'b1; Operation = OP_ADD; SrcA = 32'd1; SrcB = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL flush_over_accept: ov=%b st=%0d required ov=0 st=0", out_valid, dbg_state);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] res;
    logic z;
    int lat;
    logic seen;
    in_valid = 1'b1; Operation = OP_MUL; SrcA = 32'd7; SrcB = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0 || in_ready !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_busy: ov=%b res=%h z=%b ir=%b st=%0d required all 0",
               out_valid, ALUResult, Zero, in_ready, dbg_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_busy_release: ir=%b ov=%b required ir=1 ov=0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_busy_stale: out_valid seen=%b required 0", seen);
    end
    do_op(OP_MUL, 32'd7, 32'd6, res, z, lat);
    checks++;
    if (res !== 32'd42 || lat !== 32) begin
      failures++;
      $display("FAIL reset_mid_busy_next_mul: res=%h lat=%0d required res=2a lat=32", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    logic [31:0] res;
    logic z;
    int lat;
    v.push_back('{OP_ADD,   32'd10,       32'd20,       32'd30,       0});
    v.push_back('{OP_MULHU, 32'h00010000, 32'h00010000, 32'h1,        32});
    v.push_back('{OP_SUB,   32'd5,        32'd7,        32'hFFFFFFFE, 0});
    v.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32});
    v.push_back('{OP_XOR,   32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        0});
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, res, z, lat);
      checks++;
      if (res !== v[i].exp || lat !== v[i].lat || z !== (v[i].exp == 32'h0)) begin
        failures++;
        $display("FAIL back_to_back op=%b: res=%h lat=%0d z=%b required res=%h lat=%0d z=%b",
                 v[i].op, res, lat, z, v[i].exp, v[i].lat, v[i].exp == 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_backpressure();
    test_flush();
    test_reset_mid_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
